store_write_buffer: RTL

//  - Posted-store queue between the execute stage's store path and the data-memory write port.
//  - Accepts stores in one cycle and holds them in a DEPTH-entry in-order FIFO.
//  - Drains stores to memory one at a time using a valid/ack handshake.
//  - Forwards buffered store data to younger loads on an exact word-address match, so loads never read stale memory.

---
 rtl/store_write_buffer_pkg.sv | 13 +
 rtl/store_write_buffer_if.sv | 36 +++
 rtl/store_write_buffer_fifo_regs.sv | 74 +++++++
 rtl/store_write_buffer.sv | 108 ++++++++++
 4 files changed

// File: rtl/store_write_buffer_pkg.sv
// Shared defaults and drain-FSM state encoding for the store write buffer.
package store_write_buffer_pkg;

  localparam int SWB_ADDR_WIDTH = 32;
  localparam int SWB_DATA_WIDTH = 32;
  localparam int SWB_DEPTH      = 4;

  typedef enum logic {
    SWB_IDLE = 1'b0,
    SWB_BUSY = 1'b1
  } swb_state_e;

endpackage

// File: rtl/store_write_buffer_if.sv
// Store, load-forward and memory-write signals of the store write buffer.
interface store_write_buffer_if
  import store_write_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = SWB_ADDR_WIDTH,
  parameter int DATA_WIDTH = SWB_DATA_WIDTH
);

  logic                  st_valid;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  st_ready;

  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  ld_hit;
  logic [DATA_WIDTH-1:0] ld_data;

  logic                  mem_wrtEn;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_dataOut;
  logic                  mem_ack;

  logic                  empty;

  // The pipeline/memory side drives requests into the buffer.
  modport master (
    output st_valid, st_addr, st_data, ld_addr, mem_ack,
    input  st_ready, ld_hit, ld_data, mem_wrtEn, mem_addr, mem_dataOut, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, mem_ack,
    output st_ready, ld_hit, ld_data, mem_wrtEn, mem_addr, mem_dataOut, empty
  );

endinterface

// File: rtl/store_write_buffer_fifo_regs.sv
// In-order entry storage for the store write buffer, with an age-ordered
// view (index 0 = youngest) for the forwarding scan.
module swb_fifo_regs
  import store_write_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = SWB_ADDR_WIDTH,
  parameter int DATA_WIDTH = SWB_DATA_WIDTH,
  parameter int DEPTH      = SWB_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [ADDR_WIDTH-1:0] age_addr [DEPTH],
  output logic [DATA_WIDTH-1:0] age_data [DEPTH],
  output logic [DEPTH-1:0]      age_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  // NOTE: non-blocking (<=) in every clocked block so all registers update
  // from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the payload array has no reset; the valid bits derived from count
  // guard every read, so clearing it would only cost flops.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    logic [PTR_W-1:0] idx;
    assign idx          = wr_ptr - PTR_W'(i + 1);
    assign age_addr[i]  = addr_q[idx];
    assign age_data[i]  = data_q[idx];
    assign age_valid[i] = (CNT_W'(i) < count);
  end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store queue: accepts stores, drains them to memory over a
// valid/ack handshake and forwards buffered data to younger loads.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = SWB_ADDR_WIDTH,
  parameter int DATA_WIDTH = SWB_DATA_WIDTH,
  parameter int DEPTH      = SWB_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  store_write_buffer_if.slave  bus
);

  swb_state_e            state;
  swb_state_e            next_state;
  logic                  push;
  logic                  pop;
  logic                  load_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ADDR_WIDTH-1:0] age_addr [DEPTH];
  logic [DATA_WIDTH-1:0] age_data [DEPTH];
  logic [DEPTH-1:0]      age_valid;

  // Readiness looks at occupancy only; an ack in the same cycle does not free a slot early.
  assign bus.st_ready = ~fifo_full;
  assign push         = bus.st_valid & ~fifo_full;
  assign bus.empty    = fifo_empty & (state == SWB_IDLE);

  swb_fifo_regs #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (bus.st_addr),
    .push_data (bus.st_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_addr (head_addr),
    .head_data (head_data),
    .age_addr  (age_addr),
    .age_data  (age_data),
    .age_valid (age_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SWB_IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    next_state = state;
    load_head  = 1'b0;
    pop        = 1'b0;
    case (state)
      SWB_IDLE: begin
        if (!fifo_empty) begin
          load_head  = 1'b1;
          next_state = SWB_BUSY;
        end
      end
      SWB_BUSY: begin
        if (bus.mem_ack) begin
          pop        = 1'b1;
          next_state = SWB_IDLE;
        end
      end
      default: next_state = SWB_IDLE;
    endcase
  end

  // The head stays queued while in flight, so forwarding keeps covering it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mem_wrtEn   <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_dataOut <= '0;
    end else if (load_head) begin
      bus.mem_wrtEn   <= 1'b1;
      bus.mem_addr    <= head_addr;
      bus.mem_dataOut <= head_data;
    end else if (pop) begin
      bus.mem_wrtEn   <= 1'b0;
    end
  end

  // Walk oldest to youngest so the youngest matching store wins.
  always_comb begin
    bus.ld_hit  = 1'b0;
    bus.ld_data = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (age_valid[i] && (age_addr[i] == bus.ld_addr)) begin
        bus.ld_hit  = 1'b1;
        bus.ld_data = age_data[i];
      end
    end
  end

endmodule
